// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline decode stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: datapath sizes, opcode constants, ALU/result/immediate enums,
// the ID/EX register layout, and helpers for ALU selection and immediates.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  // addi x0,x0,0: what a bubble looks like to the execute stage
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_write;
    result_src_e       result_src;
    logic              branch;
    logic              jump;
    logic              alu_src;
    alu_op_e           alu_ctl;
    logic              valid;
    logic              illegal;
  } idex_t;

  // Empty ID/EX slot: everything zero except the NOP encoding.
  function automatic idex_t idex_bubble();
    idex_t b;
    b       = '0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  // funct3 -> ALU op; alt (funct7[5]) turns ADD into SUB and SRL into SRA.
  // Callers decide whether alt may apply to ADD (OP only).
  function automatic alu_op_e alu_from_funct3(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] imm_extend(imm_fmt_e fmt, logic [31:0] w);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{w[31]}}, w[31:20]};
      IMM_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm = {w[31:12], 12'b0};
      IMM_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2 combinational read ports, 1 synchronous write.
// Latency: reads 0 cycles (write data bypassed to a same-cycle read), write 1 edge.
// Backpressure: none; writes are always accepted, x0 writes are dropped.
//
// Ports: clk, rst_n (async active-low, clears all registers),
//        we/waddr/wdata (write port), raddr1/rdata1, raddr2/rdata2 (read ports).
module reg_file
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle write wins so decode sees the value write-back is committing.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)                   rdata1 = '0;
    else if (wr_en && waddr == raddr1)  rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)                   rdata2 = '0;
    else if (wr_en && waddr == raddr2)  rdata2 = wdata;
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control/immediate decode, register read, ID/EX register.
// Latency: 1 cycle (instruction sampled at an edge is on the *E outputs after it).
// Backpressure: stallD holds ID/EX; flushD or validF2D=0 loads a bubble.
//
// Ports: clk, rst (async active-low); InstrF2D/PCF2D/validF2D from fetch;
//        stallD/flushD hazard controls; RegWriteW/RdW/ResultW write-back port;
//        *E outputs are the registered ID/EX contents for the execute stage.
module decode_cycle
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrF2D,
  input  logic [31:0] PCF2D,
  input  logic        validF2D,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] InstrE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [3:0]  ALUControlE,
  output logic        validE,
  output logic        IllegalE
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = InstrF2D[6:0];
  assign funct3 = InstrF2D[14:12];
  assign funct7 = InstrF2D[31:25];

  // Decoder outputs
  logic        dec_legal;
  logic        dec_reg_write;
  logic        dec_mem_write;
  result_src_e dec_result_src;
  logic        dec_branch;
  logic        dec_jump;
  logic        dec_alu_src;
  alu_op_e     dec_alu_ctl;
  imm_fmt_e    dec_imm_fmt;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;

  always_comb begin
    dec_legal      = 1'b1;
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_result_src = RES_ALU;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_ctl    = ALU_ADD;
    dec_imm_fmt    = IMM_NONE;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    use_rd         = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctl   = ALU_PASSB;
        dec_imm_fmt   = IMM_U;
        use_rd        = 1'b1;
      end
      OPC_AUIPC: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_fmt   = IMM_U;
        use_rd        = 1'b1;
      end
      OPC_JAL: begin
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
        dec_result_src = RES_PC4;
        dec_alu_src    = 1'b1;
        dec_imm_fmt    = IMM_J;
        use_rd         = 1'b1;
      end
      OPC_JALR: begin
        dec_legal      = (funct3 == 3'b000);
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
        dec_result_src = RES_PC4;
        dec_alu_src    = 1'b1;
        dec_imm_fmt    = IMM_I;
        use_rs1        = 1'b1;
        use_rd         = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings
        dec_legal   = (funct3[2:1] != 2'b01);
        dec_branch  = 1'b1;
        dec_alu_ctl = ALU_SUB;
        dec_imm_fmt = IMM_B;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        // LB LH LW LBU LHU
        dec_legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec_reg_write  = 1'b1;
        dec_result_src = RES_MEM;
        dec_alu_src    = 1'b1;
        dec_imm_fmt    = IMM_I;
        use_rs1        = 1'b1;
        use_rd         = 1'b1;
      end
      OPC_STORE: begin
        // SB SH SW
        dec_legal     = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_fmt   = IMM_S;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_OPIMM: begin
        // Upper immediate bits are shift-encoding only for SLLI/SRLI/SRAI.
        if (funct3 == 3'b001)      dec_legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        dec_alu_ctl   = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_fmt   = IMM_I;
        use_rs1       = 1'b1;
        use_rd        = 1'b1;
      end
      OPC_OP: begin
        dec_legal     = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_alu_ctl   = alu_from_funct3(funct3, funct7[5]);
        dec_reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        use_rd        = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Unused operand fields read x0 so hazard logic never matches on them.
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [REG_AW-1:0] rd_idx;

  assign rs1_idx = (dec_legal && use_rs1) ? InstrF2D[19:15] : '0;
  assign rs2_idx = (dec_legal && use_rs2) ? InstrF2D[24:20] : '0;
  assign rd_idx  = (dec_legal && use_rd)  ? InstrF2D[11:7]  : '0;

  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;

  reg_file u_reg_file (
    .clk    (clk),
    .rst_n  (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (rs1_idx),
    .rdata1 (rf_rd1),
    .raddr2 (rs2_idx),
    .rdata2 (rf_rd2)
  );

  // Next ID/EX contents for a normal load
  idex_t idex_d;

  always_comb begin
    idex_d = idex_bubble();
    idex_d.pc    = PCF2D;
    idex_d.instr = InstrF2D;
    idex_d.valid = 1'b1;
    if (!dec_legal) begin
      // Illegal slot still travels as valid so EX can raise the trap.
      idex_d.illegal = 1'b1;
    end else begin
      idex_d.rd1        = rf_rd1;
      idex_d.rd2        = rf_rd2;
      idex_d.imm        = imm_extend(dec_imm_fmt, InstrF2D);
      idex_d.rs1        = rs1_idx;
      idex_d.rs2        = rs2_idx;
      idex_d.rd         = rd_idx;
      idex_d.reg_write  = dec_reg_write;
      idex_d.mem_write  = dec_mem_write;
      idex_d.result_src = dec_result_src;
      idex_d.branch     = dec_branch;
      idex_d.jump       = dec_jump;
      idex_d.alu_src    = dec_alu_src;
      idex_d.alu_ctl    = dec_alu_ctl;
    end
  end

  idex_t idex_q;

  // flush beats stall: a taken branch must kill the held instruction too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= idex_bubble();
    end else if (flushD) begin
      idex_q <= idex_bubble();
    end else if (stallD) begin
      idex_q <= idex_q;
    end else if (!validF2D) begin
      idex_q <= idex_bubble();
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign InstrE      = idex_q.instr;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ResultSrcE  = idex_q.result_src;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_ctl;
  assign validE      = idex_q.valid;
  assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases plus randomized traffic
// compared against an instruction-level reference model.
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] InstrF2D, PCF2D, ResultW;
  logic        validF2D, stallD, flushD, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, InstrE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, validE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrF2D(InstrF2D), .PCF2D(PCF2D), .validF2D(validF2D),
    .stallD(stallD), .flushD(flushD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .InstrE(InstrE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .validE(validE), .IllegalE(IllegalE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, instr;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw;
    logic [1:0]  rsrc;
    logic        br, jp, asrc;
    logic [3:0]  alu;
    logic        valid, illegal;
  } exp_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];
  exp_t        exp_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, want, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.instr = 32'h13;
    return e;
  endfunction

  // Register read as seen by decode: write-back data visible in the same cycle.
  function automatic logic [31:0] rf_read(logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWriteW && RdW == idx) return ResultW;
    return rf[idx];
  endfunction

  function automatic logic [31:0] model_imm(logic [6:0] opc, logic [31:0] w);
    int v;
    v = 0;
    case (opc)
      7'h13, 7'h03, 7'h67: v = $signed(w) >>> 20;
      7'h23: v = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
      7'h63: v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
      7'h6F: v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                 + int'(w[30:21]) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Instruction-level reference: what EX should see for word w at pc.
  function automatic exp_t model_decode(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic legal, has_rs1, has_rs2, has_rd;
    logic [3:0] alu_tab [8];
    alu_tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e = '0;
    e.pc = pc; e.instr = w; e.valid = 1'b1;
    legal = 1'b1; has_rs1 = 1'b0; has_rs2 = 1'b0; has_rd = 1'b0;
    case (opc)
      7'h37: begin e.rw = 1; e.asrc = 1; e.alu = 4'd10; has_rd = 1; end
      7'h17: begin e.rw = 1; e.asrc = 1; has_rd = 1; end
      7'h6F: begin e.rw = 1; e.jp = 1; e.rsrc = 2'b10; e.asrc = 1; has_rd = 1; end
      7'h67: begin legal = (f3 == 0); e.rw = 1; e.jp = 1; e.rsrc = 2'b10; e.asrc = 1;
                   has_rs1 = 1; has_rd = 1; end
      7'h63: begin legal = !(f3 == 2 || f3 == 3); e.br = 1; e.alu = 4'd1;
                   has_rs1 = 1; has_rs2 = 1; end
      7'h03: begin legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                   e.rw = 1; e.rsrc = 2'b01; e.asrc = 1; has_rs1 = 1; has_rd = 1; end
      7'h23: begin legal = (f3 <= 2); e.mw = 1; e.asrc = 1; has_rs1 = 1; has_rs2 = 1; end
      7'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        e.alu = (f3 == 5 && f7 == 7'h20) ? 4'd7 : alu_tab[f3];
        e.rw = 1; e.asrc = 1; has_rs1 = 1; has_rd = 1;
      end
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = (f7 == 7'h20 && f3 == 0) ? 4'd1 : (f7 == 7'h20 && f3 == 5) ? 4'd7 : alu_tab[f3];
        e.rw = 1; has_rs1 = 1; has_rs2 = 1; has_rd = 1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.pc = pc; e.instr = w; e.valid = 1'b1; e.illegal = 1'b1;
      return e;
    end
    e.rs1 = has_rs1 ? w[19:15] : 5'd0;
    e.rs2 = has_rs2 ? w[24:20] : 5'd0;
    e.rd  = has_rd  ? w[11:7]  : 5'd0;
    e.rd1 = rf_read(e.rs1);
    e.rd2 = rf_read(e.rs2);
    e.imm = model_imm(opc, w);
    return e;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".RD1E"}, RD1E, exp_q.rd1);
    chk({ctx, ".RD2E"}, RD2E, exp_q.rd2);
    chk({ctx, ".ImmExtE"}, ImmExtE, exp_q.imm);
    chk({ctx, ".PCE"}, PCE, exp_q.pc);
    chk({ctx, ".InstrE"}, InstrE, exp_q.instr);
    chk({ctx, ".Rs1E"}, 32'(Rs1E), 32'(exp_q.rs1));
    chk({ctx, ".Rs2E"}, 32'(Rs2E), 32'(exp_q.rs2));
    chk({ctx, ".RdE"}, 32'(RdE), 32'(exp_q.rd));
    chk({ctx, ".RegWriteE"}, 32'(RegWriteE), 32'(exp_q.rw));
    chk({ctx, ".MemWriteE"}, 32'(MemWriteE), 32'(exp_q.mw));
    chk({ctx, ".ResultSrcE"}, 32'(ResultSrcE), 32'(exp_q.rsrc));
    chk({ctx, ".BranchE"}, 32'(BranchE), 32'(exp_q.br));
    chk({ctx, ".JumpE"}, 32'(JumpE), 32'(exp_q.jp));
    chk({ctx, ".ALUSrcE"}, 32'(ALUSrcE), 32'(exp_q.asrc));
    chk({ctx, ".ALUControlE"}, 32'(ALUControlE), 32'(exp_q.alu));
    chk({ctx, ".validE"}, 32'(validE), 32'(exp_q.valid));
    chk({ctx, ".IllegalE"}, 32'(IllegalE), 32'(exp_q.illegal));
  endtask

  // One clock: drive inputs, predict, clock, compare everything.
  task automatic cycle(input string ctx, input logic [31:0] w, input logic [31:0] pc,
                       input logic v, input logic st, input logic fl,
                       input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    InstrF2D = w; PCF2D = pc; validF2D = v; stallD = st; flushD = fl;
    RegWriteW = rw; RdW = rdw; ResultW = res;
    if (fl)       exp_q = bubble();
    else if (st)  exp_q = exp_q;
    else if (!v)  exp_q = bubble();
    else          exp_q = model_decode(w, pc);
    if (rw && rdw != 0) rf[rdw] = res;
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic clr_model();
    exp_q = bubble();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  endtask

  initial begin
    InstrF2D = 0; PCF2D = 0; validF2D = 0; stallD = 0; flushD = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    clr_model();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // addi x1,x0,5
    cycle("addi", 32'h0050_0093, 32'h100, 1, 0, 0, 0, 0, 0);
    chk("addi_rd", 32'(RdE), 32'd1);
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_alusrc", 32'(ALUSrcE), 32'd1);
    chk("addi_regwrite", 32'(RegWriteE), 32'd1);
    chk("addi_aluctl", 32'(ALUControlE), 32'd0);
    chk("addi_valid", 32'(validE), 32'd1);

    // add x3,x2,x0 while write-back commits x2
    cycle("bypass", 32'h0001_01B3, 32'h104, 1, 0, 0, 1, 5'd2, 32'hDEAD);
    chk("bypass_rd1", RD1E, 32'hDEAD);
    cycle("x2_read", 32'h0001_0233, 32'h108, 1, 0, 0, 0, 0, 0);
    chk("x2_later_rd1", RD1E, 32'hDEAD);

    // x0 writes are dropped, including the same-cycle path
    cycle("x0_wr", 32'h0000_02B3, 32'h10C, 1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    chk("x0_bypass_rd1", RD1E, 32'h0);
    cycle("x0_rd", 32'h0000_02B3, 32'h110, 1, 0, 0, 0, 0, 0);
    chk("x0_rd1", RD1E, 32'h0);

    // beq x1,x2,+8 then two stall cycles with a different word presented
    cycle("beq", 32'h0020_8463, 32'h114, 1, 0, 0, 0, 0, 0);
    chk("beq_branch", 32'(BranchE), 32'd1);
    chk("beq_imm", ImmExtE, 32'd8);
    for (int i = 0; i < 2; i++) begin
      cycle("stall", 32'h0050_0093, 32'h118, 1, 1, 0, 1, 5'd9, 32'h55);
      chk("stall_instr", InstrE, 32'h0020_8463);
      chk("stall_pc", PCE, 32'h114);
    end
    cycle("flush_stall", 32'h0050_0093, 32'h118, 1, 1, 1, 0, 0, 0);
    chk("flush_valid", 32'(validE), 32'd0);
    chk("flush_instr", InstrE, 32'h13);
    chk("flush_branch", 32'(BranchE), 32'd0);

    cycle("sw", 32'hFE53_2E23, 32'h120, 1, 0, 0, 0, 0, 0);
    chk("sw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("sw_memwrite", 32'(MemWriteE), 32'd1);
    cycle("jal", 32'hFF9F_F0EF, 32'h124, 1, 0, 0, 0, 0, 0);
    chk("jal_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("jal_jump", 32'(JumpE), 32'd1);
    chk("jal_rsrc", 32'(ResultSrcE), 32'd2);
    cycle("lui", 32'hABCD_E3B7, 32'h128, 1, 0, 0, 0, 0, 0);
    chk("lui_imm", ImmExtE, 32'hABCD_E000);
    cycle("illegal", 32'hFFFF_FFFF, 32'h12C, 1, 0, 0, 0, 0, 0);
    chk("ill_flag", 32'(IllegalE), 32'd1);
    chk("ill_regwrite", 32'(RegWriteE), 32'd0);
    chk("ill_memwrite", 32'(MemWriteE), 32'd0);
    chk("ill_valid", 32'(validE), 32'd1);

    // Asynchronous reset between edges
    cycle("pre_rst", 32'h0001_0233, 32'h130, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    clr_model();
    check_all("async_rst");
    #2 rst = 1'b1;
    cycle("post_rst", 32'h0001_0233, 32'h134, 1, 0, 0, 0, 0, 0);
    chk("rst_clears_x2", RD1E, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  opcs [9];
      logic [31:0] w;
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      w = $urandom();
      if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
        w[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
      cycle("rand", w, $urandom(), $urandom_range(0, 9) != 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
